// File: rtl/wire_alu_seq.sv
// wire_alu_seq: per-channel sequential add/sub/accumulate/clear engine with sticky overflow flags
module wire_alu_seq #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4
) (
  input  logic                 ti_clk,
  input  logic                 ti_rst_n,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 sat_en,
  input  logic                 ovf_clr,
  input  logic [NCH*WIDTH-1:0] op_a,
  input  logic [NCH*WIDTH-1:0] op_b,
  output logic [NCH*WIDTH-1:0] result,
  output logic [NCH-1:0]       ovf,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam logic [1:0] M_SUB = 2'd1, M_ACC = 2'd2, M_CLR = 2'd3;
  logic [1:0]           r_state, r_mode;
  logic [CW-1:0]        r_cnt;
  logic                 r_sat;
  logic [NCH*WIDTH-1:0] r_a, r_b, r_result;
  logic [NCH-1:0]       r_ovf, w_wr, w_set;
  logic [WIDTH-1:0]     w_a, w_b, w_r, w_new;
  logic [WIDTH:0]       w_ext;
  logic                 w_of, w_last;
  always_comb begin
    w_a  = '0;
    w_b  = '0;
    w_r  = '0;
    w_wr = '0;
    for (int i = 0; i < NCH; i++)
      if (r_cnt == i[CW-1:0]) begin
        w_a     = r_a[i*WIDTH +: WIDTH];
        w_b     = r_b[i*WIDTH +: WIDTH];
        w_r     = r_result[i*WIDTH +: WIDTH];
        w_wr[i] = r_state == RUN;
      end
  end
  // ACC adds the live result register of the active channel, not a snapshot
  assign w_ext  = r_mode == M_SUB ? {1'b0, w_a} - {1'b0, w_b} :
                  r_mode == M_ACC ? {1'b0, w_r} + {1'b0, w_a} : {1'b0, w_a} + {1'b0, w_b};
  assign w_of   = w_ext[WIDTH] && r_mode != M_CLR;
  assign w_new  = r_mode == M_CLR ? '0 :
                  (w_of && r_sat) ? {WIDTH{r_mode != M_SUB}} : w_ext[WIDTH-1:0];
  assign w_set  = w_of ? w_wr : '0;
  assign w_last = r_cnt == CW'(NCH - 1);
  always_ff @(posedge ti_clk or negedge ti_rst_n) begin
    if (!ti_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_mode   <= '0;
      r_sat    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_ovf    <= '0;
    end else begin
      r_ovf <= (ovf_clr ? '0 : r_ovf) | w_set;
      for (int i = 0; i < NCH; i++)
        if (w_wr[i]) r_result[i*WIDTH +: WIDTH] <= w_new;
      if (r_state == IDLE && start) begin
        r_a     <= op_a;
        r_b     <= op_b;
        r_mode  <= mode;
        r_sat   <= sat_en;
        r_cnt   <= '0;
        r_state <= RUN;
      end else if (r_state == RUN) begin
        r_cnt   <= r_cnt + 1'b1;
        r_state <= w_last ? DONE : RUN;
      end else if (r_state == DONE) begin
        r_state <= IDLE;
      end
    end
  end
  assign result = r_result;
  assign ovf    = r_ovf;
  assign busy   = r_state != IDLE;
  assign done   = r_state == DONE;
endmodule
